// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU issue/writeback controller:
// opcode and condition-code encodings, flag bit positions and the
// per-opcode flag write mask.
package alu_ctrl_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Branch condition codes
  localparam logic [2:0] CC_NE  = 3'b000;  // Z=0
  localparam logic [2:0] CC_EQ  = 3'b001;  // Z=1
  localparam logic [2:0] CC_GT  = 3'b010;  // Z=0 and N=0
  localparam logic [2:0] CC_LT  = 3'b011;  // N=1
  localparam logic [2:0] CC_GE  = 3'b100;  // Z=1 or N=0
  localparam logic [2:0] CC_LE  = 3'b101;  // N=1 or Z=1
  localparam logic [2:0] CC_OVF = 3'b110;  // V=1
  localparam logic [2:0] CC_UNC = 3'b111;  // always

  // Flag bit positions inside {N,V,Z}
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Which flag bits an opcode updates when it commits.
  function automatic logic [2:0] flag_wmask(input logic [3:0] op);
    logic [2:0] mask;
    mask = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b001;
      default:                        mask = 3'b000;
    endcase
    return mask;
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_B) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/alu_br_cond.sv
// Branch condition evaluator: combinational (ccode, {N,V,Z}) -> taken.
module alu_br_cond
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] ccode,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n;
  logic v;
  logic z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  // Decode the condition code against the committed flags.
  always_comb begin
    // NOTE: default assignment first so every path drives taken; no latch.
    taken = 1'b0;
    case (ccode)
      CC_NE:   taken = !z;
      CC_EQ:   taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GE:   taken = z || !n;
      CC_LE:   taken = n || z;
      CC_OVF:  taken = v;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/writeback controller around the EX-stage ALU.
// Issue register drives the ALU opcode, writeback register captures the
// result for EX/MEM, flag register holds committed {N,V,Z}, and branches
// resolve against those flags as they commit.
// Optional build macro: ALU_CTRL_PERF_EN enables the saturating
// perf_ops / perf_stall counters; otherwise both ports read zero.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [2:0]  in_ccode,
  input  logic        flush,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_result,
  input  logic [2:0]  alu_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_opcode,
  output logic [2:0]  flags,
  output logic        br_valid,
  output logic        br_taken,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_stall
);

  logic       iv;
  logic [3:0] iop;
  logic [2:0] icc;
  logic       commit;
  logic       accept;
  logic       cond_taken;
  logic [2:0] wmask;

  // A held op commits when the writeback slot is free or draining; a flush
  // kills it instead.
  assign commit     = iv && (!out_valid || out_ready) && !flush;
  assign in_ready   = !iv || commit;
  assign accept     = in_valid && in_ready && !flush;
  assign alu_opcode = iv ? iop : 4'h0;
  assign wmask      = flag_wmask(iop);

  alu_br_cond u_br_cond (
    .ccode (icc),
    .flags (flags),
    .taken (cond_taken)
  );

  // Issue register: flush wins, then a new accept, then drain on commit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (rst) begin
      iv  <= 1'b0;
      iop <= 4'h0;
      icc <= 3'b000;
    end else if (flush) begin
      iv <= 1'b0;
    end else if (accept) begin
      iv  <= 1'b1;
      iop <= in_opcode;
      icc <= in_ccode;
    end else if (commit) begin
      iv <= 1'b0;
    end
  end

  // Writeback register: load on commit, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_opcode <= 4'h0;
    end else if (commit) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_opcode <= iop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flag register: only the bits the committing opcode owns are replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= FLAG_RST;
    end else if (commit) begin
      flags <= (flags & ~wmask) | (alu_flag & wmask);
    end
  end

  // Branch resolution pulse, aligned with the branch's out_valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_valid <= commit && is_branch(iop);
      br_taken <= commit && is_branch(iop) && cond_taken;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic [15:0] ops_q;
  logic [15:0] stall_q;

  // Saturating committed-op and backpressure-cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q   <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      if (commit && (ops_q != 16'hFFFF)) begin
        ops_q <= ops_q + 16'd1;
      end
      if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`else
  assign perf_ops   = 16'h0000;
  assign perf_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [2:0]  in_ccode;
  logic        flush;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic [2:0]  alu_flag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_opcode;
  logic [2:0]  flags;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] perf_ops;
  logic [15:0] perf_stall;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_ccode   (in_ccode),
    .flush      (flush),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .flags      (flags),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: the instruction waiting in EX, the result waiting for
  // EX/MEM, the architectural flags and the last branch resolution.
  bit          m_held;
  logic [3:0]  m_hop;
  logic [2:0]  m_hcc;
  bit          m_wb;
  logic [15:0] m_res;
  logic [3:0]  m_wop;
  logic [2:0]  m_flags;
  bit          m_brv;
  bit          m_brt;
  int          m_ops;
  int          m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // N/V/Z after an op commits: arithmetic sets all three, logic/shift
  // ops only set Z, everything else leaves the flags alone.
  function automatic logic [2:0] next_flags(input logic [3:0] op, input logic [2:0] old,
                                            input logic [2:0] af);
    if (op == 4'h0 || op == 4'h1) return af;
    if (op >= 4'h3 && op <= 4'h6) return {old[2], old[1], af[0]};
    return old;
  endfunction

  function automatic bit branch_taken(input logic [2:0] cc, input logic [2:0] f);
    bit n;
    bit v;
    bit z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (cc)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_held  = 0; m_hop = 4'h0; m_hcc = 3'b000;
    m_wb    = 0; m_res = 16'h0; m_wop = 4'h0;
    m_flags = 3'b000;
    m_brv   = 0; m_brt = 0;
    m_ops   = 0; m_stall = 0;
  endtask

  // Compare every output against the model, then advance the model across
  // the coming clock edge. Called at a negedge with inputs already driven.
  task automatic step();
    bit sink_free;
    bit fires;
    bit ready_now;
    bit taken_in;
    #1;
    sink_free = !m_wb || out_ready;
    fires     = m_held && sink_free && !flush;
    ready_now = !m_held || fires;
    if (cmp_en) begin
      check("in_ready", in_ready, ready_now);
      check("alu_opcode", alu_opcode, m_held ? m_hop : 4'h0);
      check("out_valid", out_valid, m_wb);
      if (m_wb) begin
        check("out_result", out_result, m_res);
        check("out_opcode", out_opcode, m_wop);
      end
      check("flags", flags, m_flags);
      check("br_valid", br_valid, m_brv);
      if (m_brv) check("br_taken", br_taken, m_brt);
      check("perf_ops", perf_ops, PERF_ON ? m_ops : 0);
      check("perf_stall", perf_stall, PERF_ON ? m_stall : 0);
    end
    if (rst) begin
      model_reset();
    end else begin
      taken_in = in_valid && ready_now && !flush;
      if (m_wb && !out_ready && m_stall < 65535) m_stall++;
      if (fires && m_ops < 65535) m_ops++;
      m_brv = fires && (m_hop == 4'hC || m_hop == 4'hD);
      m_brt = m_brv && branch_taken(m_hcc, m_flags);
      if (fires) begin
        m_flags = next_flags(m_hop, m_flags, alu_flag);
        m_wb  = 1;
        m_res = alu_result;
        m_wop = m_hop;
      end else if (out_ready) begin
        m_wb = 0;
      end
      if (flush) m_held = 0;
      else if (taken_in) begin
        m_held = 1; m_hop = in_opcode; m_hcc = in_ccode;
      end else if (fires) m_held = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [2:0] cc);
    in_valid  = v;
    in_opcode = op;
    in_ccode  = cc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    alu_result = 16'h0; alu_flag = 3'b000;
    drive(0, 4'h0, 3'b000);
    model_reset();
    @(negedge clk);
    step();
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_flags", flags, 3'b000);
    check("rst_alu_opcode", alu_opcode, 4'h0);
    check("rst_br_valid", br_valid, 1'b0);

    // SUB sets Z, then an EQ branch sees it one commit later
    drive(1, 4'h1, 3'b000); alu_flag = 3'b000; step();
    drive(1, 4'hC, 3'b001); alu_flag = 3'b001; alu_result = 16'h1234;
    #1 check("sub_alu_opcode", alu_opcode, 4'h1);
    step();
    check("sub_flags", flags, 3'b001);
    check("sub_out_result", out_result, 16'h1234);
    check("sub_out_opcode", out_opcode, 4'h1);
    drive(0, 4'h0, 3'b000); alu_flag = 3'b000; step();
    check("br_valid_eq", br_valid, 1'b1);
    check("br_taken_eq", br_taken, 1'b1);
    check("br_out_opcode", out_opcode, 4'hC);
    step();
    check("br_pulse_end", br_valid, 1'b0);

    // XOR only owns Z
    drive(1, 4'h0, 3'b000); step();
    drive(1, 4'h3, 3'b000); alu_flag = 3'b110; step();
    check("add_flags", flags, 3'b110);
    drive(0, 4'h0, 3'b000); alu_flag = 3'b110; step();
    check("xor_flags", flags, 3'b110);
    step();

    // Backpressure: two ops in flight, sink stalls for five cycles
    drive(1, 4'h2, 3'b000); out_ready = 1'b1; step();
    drive(1, 4'h8, 3'b000); out_ready = 1'b0; alu_result = 16'hAAAA; step();
    drive(0, 4'h0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      alu_result = 16'($urandom);
      #1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_result", out_result, 16'hAAAA);
      step();
    end
    check("stall_count", perf_stall, PERF_ON ? 16'd5 : 16'd0);
    out_ready = 1'b1; step();
    step();
    step();

    // Flush kills the held ADD and refuses the SUB offered alongside it
    drive(1, 4'h0, 3'b000); step();
    flush = 1'b1; drive(1, 4'h1, 3'b000); alu_flag = 3'b111; step();
    flush = 1'b0; drive(0, 4'h0, 3'b000);
    check("flush_alu_opcode", alu_opcode, 4'h0);
    check("flush_flags", flags, 3'b110);
    check("flush_out_valid", out_valid, 1'b0);
    step();
    check("flush_out_valid2", out_valid, 1'b0);

    // Reset while a result is waiting
    drive(1, 4'h2, 3'b000); step();
    drive(0, 4'h0, 3'b000); out_ready = 1'b0; step();
    check("pre_rst_out_valid", out_valid, 1'b1);
    rst = 1'b1; step();
    rst = 1'b0; out_ready = 1'b1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_perf_ops", perf_ops, 16'd0);
    check("mid_rst_perf_stall", perf_stall, 16'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      alu_result = 16'($urandom);
      alu_flag   = 3'($urandom);
      drive($urandom_range(0, 3) != 0, 4'($urandom), 3'($urandom));
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Two-stage issue/writeback controller wrapped around the EX-stage ALU. It accepts decoded instructions from ID/EX over a valid/ready handshake, holds each one in an issue register that drives the ALU opcode, captures the ALU result into a writeback register for EX/MEM, and owns the architectural N/V/Z flag register. It also evaluates branch conditions against that flag register and resolves each branch as it leaves EX.

## Interface
- FLAG_RST, 3'b000: reset value of the flag register, ordered {N,V,Z}.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID/EX presents an instruction.
- in_ready  out  1  controller accepts this cycle.
- in_opcode  in  4  instruction opcode.
- in_ccode  in  3  branch condition code; meaningful only for branches.
- flush  in  1  kill the instruction held in the issue register.
- alu_opcode  out  4  opcode driven to the ALU.
- alu_result  in  16  ALU OutputB.
- alu_flag  in  3  raw ALU flags {N,V,Z}.
- out_valid  out  1  writeback register holds a result.
- out_ready  in  1  EX/MEM consumes.
- out_result  out  16  registered result.
- out_opcode  out  4  registered opcode.
- flags  out  3  committed {N,V,Z}.
- br_valid  out  1  one-cycle pulse; a branch left EX.
- br_taken  out  1  branch resolution, valid with br_valid.
- perf_ops  out  16  committed-op counter.
- perf_stall  out  16  backpressure-cycle counter.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 RED, 3 XOR, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB.
  - 8 LW, 9 SW, A LHB, B LLB.
  - C B, D BR, E PCS, F HLT.
- Issue register (iv, iop, icc):
  - alu_opcode = iop whenever iv=1.
  - alu_opcode = 4'h0 when iv=0.
- Writeback register:
  - Loads when iv && (!out_valid || out_ready). This load is the "commit".
  - Captures alu_result and iop.
- Handshake:
  - in_ready = !iv || commit.
  - Accept = in_valid && in_ready && !flush.
- Flag commit masks:
  - ADD/SUB: write N, V, Z.
  - XOR/SLL/SRA/ROR: write Z only.
  - All other opcodes leave flags unchanged.
- Branch conditions on committed flags, evaluated at commit of opcode C/D:
  - 000 Z=0; 001 Z=1; 010 Z=0&&N=0; 011 N=1.
  - 100 Z=1||N=0; 101 N=1||Z=1; 110 V=1; 111 always.
- Flush:
  - Clears iv at the clock edge. No commit occurs that cycle and flags are untouched.
  - An instruction presented in the same cycle is not accepted (flush wins).
  - out_valid is not affected.
- perf_ops increments on each commit. perf_stall increments each cycle with out_valid && !out_ready. Both saturate at 16'hFFFF.

## Timing
- Reset values:
  - iv=0, out_valid=0, out_result=0, out_opcode=0.
  - flags=FLAG_RST, br_valid=0, br_taken=0, perf_*=0, alu_opcode=0.
- Latency: accept at edge N → iv=1 during cycle N+1 → commit at edge N+1 → out_valid during N+2.
- Throughput: 1 op/cycle while out_ready=1.
- Backpressure:
  - out_valid && !out_ready holds both registers, so in_ready=0 while iv=1.
  - out_result and out_opcode are stable while out_valid && !out_ready.
- A flag setter committing at edge K is visible to a branch committing at edge K+1 or later. There are no flag hazards and no stall cycles.
- br_valid/br_taken are registered and assert in the same cycle as the branch's out_valid.
- When no branch commits, br_valid deasserts the next cycle.
- rst mid-operation drops both registers without emitting any output.

## Configuration
- ALU_CTRL_PERF_EN:
  - Defined: perf_ops and perf_stall count as described in Operation.
  - Undefined: both ports are tied to 16'h0000 and no counter flops are built.
  - Ports are present in both builds.

## Structure
- Package alu_ctrl_pkg holds:
  - Opcode localparams.
  - Condition-code localparams.
  - Flag bit indices: N=2, V=1, Z=0.
  - Per-opcode flag-write-mask function.
- Sub-module alu_br_cond: combinational (ccode[2:0], flags[2:0]) → taken.

## Test plan
- Reset → out_valid=0, flags=FLAG_RST, alu_opcode=0.
- Back-to-back stream, out_ready=1:
  - Stimulus: SUB with alu_flag=3'b001, then branch cc=001.
  - Response: flags=001 after the SUB; br_valid=1 and br_taken=1 two cycles after the branch is accepted.
- XOR with alu_flag=3'b110 after ADD with flags=3'b110 → flags=3'b110; N and V are kept, Z=0 is written.
- out_ready low for 5 cycles with 2 instructions in flight → in_ready=0, out_result stable, perf_stall=5 (PERF build) or 0 (non-PERF build).
- flush together with in_valid while iv=1 → held op never reaches out_valid, new op is not accepted, flags are unchanged.
- Assert rst while out_valid=1 → out_valid=0 next cycle, perf counters=0.
